// File: rtl/game_controller.sv
// Connect-four style game controller: owns the board, validates drops,
// places pieces under gravity and evaluates wins one direction per cycle.
//
// Handshake: start and drop are single-cycle request pulses sampled on the
// rising edge of clk; there is no ready/acknowledge. A drop is only taken
// in P1_TURN/P2_TURN while busy is low; otherwise it is silently discarded.
// An accepted drop raises busy for exactly five cycles, a rejected one
// pulses move_err for one cycle instead.
module game_controller #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] col,
    input  logic       drop,
    output logic [1:0] state,
    output logic [1:0] game_status,
    output logic       busy,
    output logic       move_err
);

    localparam int CELLS = ROWS * COLS;
    // The move counter is 6 bits, so an 8x8 board wraps to zero on its
    // 64th move; the counter is never zero right after a move otherwise,
    // so comparing against the wrapped value still identifies a full board.
    localparam logic [5:0] FULL_COUNT = 6'(CELLS % 64);

    typedef enum logic [1:0] {
        GAME_INIT = 2'b00,
        P1_TURN   = 2'b01,
        P2_TURN   = 2'b10,
        END_GAME  = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } status_e;

    typedef logic [ROWS-1:0][COLS-1:0][1:0] board_t;

    phase_e     state_q, state_d;
    status_e    status_q, status_d;
    board_t     board;
    logic [5:0] move_cnt;
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic [2:0] eval_step;
    logic       win_q;
    logic       busy_q;
    logic       move_err_q;

    logic       do_clear;
    logic       do_accept;
    logic       do_reject;
    logic       col_ok;
    logic       col_full;
    logic [2:0] drop_row;
    logic [1:0] mover;
    logic       dir_win;
    int         dr;
    int         dc;

    // Player codes coincide with the turn encodings (P1=01, P2=10).
    assign mover = state_q;

    // Out-of-board coordinates read as empty, which clips every run.
    function automatic logic [1:0] cell_at(input board_t b, input int r, input int c);
        logic [1:0] v;
        v = 2'b00;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if (i == r && j == c) begin
                    v = b[i][j];
                end
            end
        end
        return v;
    endfunction

    // Length of the same-player run leaving (r0, c0) in one sense; three is
    // the most that can matter for a four-in-a-row.
    function automatic int run_len(input board_t b, input int r0, input int c0,
                                   input int sr, input int sc, input logic [1:0] p);
        int   n;
        logic go;
        n  = 0;
        go = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            if (go && cell_at(b, r0 + sr * k, c0 + sc * k) == p) begin
                n = n + 1;
            end else begin
                go = 1'b0;
            end
        end
        return n;
    endfunction

    // Column legality and the landing row for the requested column.
    always_comb begin
        col_ok   = {1'b0, col} < 4'(COLS);
        col_full = cell_at(board, ROWS - 1, int'(col)) != 2'b00;
        drop_row = 3'd0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (cell_at(board, r, int'(col)) == 2'b00) begin
                drop_row = 3'(r);
            end
        end
    end

    // Win test for the direction selected by the current evaluation step.
    always_comb begin
        dr      = 0;
        dc      = 0;
        dir_win = 1'b0;
        case (eval_step)
            3'd0: begin dr = 0;  dc = 1; end
            3'd1: begin dr = 1;  dc = 0; end
            3'd2: begin dr = 1;  dc = 1; end
            3'd3: begin dr = -1; dc = 1; end
            default: ;
        endcase
        if (dr != 0 || dc != 0) begin
            dir_win = (1 + run_len(board, int'(row_q), int'(col_q), dr, dc, mover)
                         + run_len(board, int'(row_q), int'(col_q), -dr, -dc, mover)) >= 4;
        end
    end

    // Next phase/result and the per-cycle command decode.
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        do_clear  = 1'b0;
        do_accept = 1'b0;
        do_reject = 1'b0;
        case (state_q)
            GAME_INIT, END_GAME: begin
                if (start) begin
                    do_clear = 1'b1;
                    state_d  = P1_TURN;
                    status_d = STILL_PLAYING;
                end
            end
            P1_TURN, P2_TURN: begin
                if (busy_q) begin
                    if (eval_step == 3'd4) begin
                        if (win_q) begin
                            state_d  = END_GAME;
                            status_d = (state_q == P1_TURN) ? P1_WINS : P2_WINS;
                        end else if (move_cnt == FULL_COUNT) begin
                            state_d  = END_GAME;
                            status_d = TIE;
                        end else begin
                            state_d = (state_q == P1_TURN) ? P2_TURN : P1_TURN;
                        end
                    end
                end else if (drop) begin
                    if (col_ok && !col_full) begin
                        do_accept = 1'b1;
                    end else begin
                        do_reject = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Phase and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= GAME_INIT;
            status_q <= STILL_PLAYING;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
        end
    end

    // Board, move counter and the five-cycle evaluation sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            board      <= '0;
            move_cnt   <= 6'd0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            eval_step  <= 3'd0;
            win_q      <= 1'b0;
            busy_q     <= 1'b0;
            move_err_q <= 1'b0;
        end else begin
            move_err_q <= do_reject;
            if (do_clear) begin
                board    <= '0;
                move_cnt <= 6'd0;
                win_q    <= 1'b0;
            end else if (do_accept) begin
                for (int i = 0; i < ROWS; i++) begin
                    for (int j = 0; j < COLS; j++) begin
                        if (i == int'(drop_row) && j == int'(col)) begin
                            board[i][j] <= mover;
                        end
                    end
                end
                move_cnt  <= move_cnt + 6'd1;
                row_q     <= drop_row;
                col_q     <= col;
                eval_step <= 3'd0;
                win_q     <= 1'b0;
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                if (eval_step == 3'd4) begin
                    busy_q    <= 1'b0;
                    eval_step <= 3'd0;
                end else begin
                    win_q     <= win_q | dir_win;
                    eval_step <= eval_step + 3'd1;
                end
            end
        end
    end

    assign state       = state_q;
    assign game_status = status_q;
    assign busy        = busy_q;
    assign move_err    = move_err_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: a reference board model predicts every move,
// accepted moves push their expected {state, game_status} to a queue that
// is popped when busy falls.
module tb_game_controller;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int BW   = ROWS * COLS * 2;

    localparam int K_IGNORE = 0;
    localparam int K_REJECT = 1;
    localparam int K_ACCEPT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] col;
    logic       drop;
    logic [1:0] state;
    logic [1:0] game_status;
    logic       busy;
    logic       move_err;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    int mb[ROWS][COLS];
    int m_state;
    int m_status;
    int m_cnt;

    game_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .col        (col),
        .drop       (drop),
        .state      (state),
        .game_status(game_status),
        .busy       (busy),
        .move_err   (move_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit model_win(input int p);
        int dr, dc, rr, cc;
        bit all;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                for (int d = 0; d < 4; d++) begin
                    case (d)
                        0: begin dr = 0;  dc = 1; end
                        1: begin dr = 1;  dc = 0; end
                        2: begin dr = 1;  dc = 1; end
                        default: begin dr = -1; dc = 1; end
                    endcase
                    all = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        rr = r + dr * k;
                        cc = c + dc * k;
                        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                            all = 1'b0;
                        end else if (mb[rr][cc] != p) begin
                            all = 1'b0;
                        end
                    end
                    if (all) return 1'b1;
                end
            end
        end
        return 1'b0;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mb[r][c] = 0;
        m_cnt = 0;
    endtask

    task automatic model_start();
        if (m_state == 0 || m_state == 3) begin
            model_clear();
            m_state  = 1;
            m_status = 0;
        end
    endtask

    task automatic model_drop(input int c, output int kind);
        int r;
        if (m_state != 1 && m_state != 2) begin
            kind = K_IGNORE;
        end else if (c >= COLS) begin
            kind = K_REJECT;
        end else if (mb[ROWS-1][c] != 0) begin
            kind = K_REJECT;
        end else begin
            r = 0;
            while (mb[r][c] != 0) r++;
            mb[r][c] = m_state;
            m_cnt++;
            if (model_win(m_state)) begin
                m_status = m_state;
                m_state  = 3;
            end else if (m_cnt == ROWS * COLS) begin
                m_state  = 3;
                m_status = 3;
            end else begin
                m_state = 3 - m_state;
            end
            kind = K_ACCEPT;
        end
    endtask

    function automatic logic [BW-1:0] model_board_vec();
        logic [BW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r * COLS + c) * 2 +: 2] = 2'(mb[r][c]);
        return v;
    endfunction

    function automatic logic [BW-1:0] dut_board_vec();
        logic [BW-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r * COLS + c) * 2 +: 2] = dut.board[r][c];
        return v;
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        drop  = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        m_state  = 0;
        m_status = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start();
        model_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drives one drop and settles it against the model and the scoreboard.
    task automatic drop_move(input int c, input string tag);
        int kind, pre_state, pre_status, n;
        logic [3:0] e;
        pre_state  = m_state;
        pre_status = m_status;
        model_drop(c, kind);
        if (kind == K_ACCEPT) exp_q.push_back({2'(m_state), 2'(m_status)});
        col  = 3'(c);
        drop = 1'b1;
        @(posedge clk); #1;
        drop = 1'b0;
        if (kind == K_ACCEPT) begin
            n = 0;
            while (busy === 1'b1 && n < 20) begin
                n++;
                checks++;
                if ({state, game_status} !== {2'(pre_state), 2'(pre_status)}) begin
                    errors++;
                    $display("FAIL %s hold: state/status=%b expected %b", tag,
                             {state, game_status}, {2'(pre_state), 2'(pre_status)});
                end
                @(posedge clk); #1;
            end
            checks++;
            if (n != 5) begin
                errors++;
                $display("FAIL %s busy_len: busy cycles=%0d expected 5", tag, n);
            end
            e = exp_q.pop_front();
            checks++;
            if ({state, game_status} !== e) begin
                errors++;
                $display("FAIL %s result: state/status=%b expected %b", tag,
                         {state, game_status}, e);
            end
        end else if (kind == K_REJECT) begin
            checks++;
            if (move_err !== 1'b1 || busy !== 1'b0 || state !== 2'(pre_state)) begin
                errors++;
                $display("FAIL %s reject: move_err=%b busy=%b state=%b expected 1 0 %b",
                         tag, move_err, busy, state, 2'(pre_state));
            end
            @(posedge clk); #1;
            checks++;
            if (move_err !== 1'b0) begin
                errors++;
                $display("FAIL %s err_pulse: move_err=%b expected 0", tag, move_err);
            end
        end else begin
            checks++;
            if (move_err !== 1'b0 || busy !== 1'b0 ||
                {state, game_status} !== {2'(pre_state), 2'(pre_status)}) begin
                errors++;
                $display("FAIL %s ignore: move_err=%b busy=%b state/status=%b expected 0 0 %b",
                         tag, move_err, busy, {state, game_status},
                         {2'(pre_state), 2'(pre_status)});
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        drop  = 1'b1;
        col   = 3'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_clear();
        m_state  = 0;
        m_status = 0;
        checks++;
        if ({state, game_status, busy, move_err} !== 6'b000000) begin
            errors++;
            $display("FAIL reset_outputs: state=%b status=%b busy=%b move_err=%b expected 00 00 0 0",
                     state, game_status, busy, move_err);
        end
        checks++;
        if (dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL reset_board: board=%h expected %h", dut_board_vec(), model_board_vec());
        end
        reset = 1'b0;
        start = 1'b0;
        drop  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: state=%b expected 00", state);
        end
    endtask

    task automatic test_first_move();
        apply_reset();
        pulse_start();
        checks++;
        if ({state, game_status} !== 4'b0100) begin
            errors++;
            $display("FAIL start: state/status=%b expected 0100", {state, game_status});
        end
        drop_move(3, "first_drop");
        checks++;
        if (dut.board[0][3] !== 2'b01 || dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL first_board: board=%h expected %h", dut_board_vec(), model_board_vec());
        end
        // start during a turn must be ignored
        pulse_start();
        checks++;
        if ({state, game_status} !== 4'b1000 || dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL start_in_turn: state/status=%b board=%h expected 1000 %h",
                     {state, game_status}, dut_board_vec(), model_board_vec());
        end
    endtask

    task automatic test_horizontal_win();
        int seq[$] = '{0, 6, 1, 6, 2, 6, 3};
        apply_reset();
        pulse_start();
        foreach (seq[i]) drop_move(seq[i], "hwin");
        checks++;
        if ({state, game_status} !== 4'b1101) begin
            errors++;
            $display("FAIL hwin_final: state/status=%b expected 1101", {state, game_status});
        end
        drop_move(4, "hwin_after");
        checks++;
        if (dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL hwin_board: board=%h expected %h", dut_board_vec(), model_board_vec());
        end
    endtask

    task automatic test_column_full();
        apply_reset();
        pulse_start();
        for (int i = 0; i < ROWS; i++) drop_move(2, "fill");
        drop_move(2, "full_col");
        checks++;
        if (dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL full_board: board=%h expected %h", dut_board_vec(), model_board_vec());
        end
        drop_move(7, "bad_col");
        checks++;
        if (dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL badcol_board: board=%h expected %h", dut_board_vec(), model_board_vec());
        end
        drop_move(0, "after_reject");
    endtask

    task automatic test_tie();
        int pairs[$] = '{0, 2, 1, 3, 4, 6};
        int win_seq[$] = '{1, 1, 1, 1, 1, 1,
                           0, 2, 2, 0, 0, 2, 2, 0, 0, 2, 2,
                           3, 3, 3, 3, 3, 3,
                           6, 6, 6, 6, 6,
                           4, 4, 4, 4, 5, 5, 5, 5, 4, 5, 4, 5, 0, 6};
        apply_reset();
        pulse_start();
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 3; k++) begin
                drop_move(pairs[2*p],   "tie");
                drop_move(pairs[2*p+1], "tie");
                drop_move(pairs[2*p+1], "tie");
                drop_move(pairs[2*p],   "tie");
            end
        end
        for (int k = 0; k < ROWS; k++) drop_move(5, "tie");
        checks++;
        if ({state, game_status} !== 4'b1111) begin
            errors++;
            $display("FAIL tie_final: state/status=%b expected 1111", {state, game_status});
        end
        apply_reset();
        pulse_start();
        foreach (win_seq[i]) drop_move(win_seq[i], "last_diag");
        checks++;
        if ({state, game_status} !== 4'b1110) begin
            errors++;
            $display("FAIL last_diag_final: state/status=%b expected 1110", {state, game_status});
        end
    endtask

    task automatic test_busy_drop();
        int kind;
        apply_reset();
        pulse_start();
        model_drop(0, kind);
        col  = 3'd0;
        drop = 1'b1;
        @(posedge clk); #1;          // E0
        drop = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b expected 1", busy);
        end
        @(posedge clk); #1;          // E1
        col  = 3'd1;
        drop = 1'b1;
        @(posedge clk); #1;          // E2 sees the second drop
        drop  = 1'b0;
        checks++;
        if (dut_board_vec() !== model_board_vec() || move_err !== 1'b0) begin
            errors++;
            $display("FAIL busy_drop: board=%h move_err=%b expected %h 0",
                     dut_board_vec(), move_err, model_board_vec());
        end
        reset = 1'b1;
        @(posedge clk); #1;          // E3 with reset
        reset = 1'b0;
        model_clear();
        m_state  = 0;
        m_status = 0;
        checks++;
        if ({state, game_status, busy, move_err} !== 6'b000000 ||
            dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL abort: state=%b status=%b busy=%b board=%h expected 00 00 0 %h",
                     state, game_status, busy, dut_board_vec(), model_board_vec());
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({state, game_status, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL abort_quiet: state=%b status=%b busy=%b expected 00 00 0",
                     state, game_status, busy);
        end
    endtask

    task automatic test_vertical_p2();
        int seq[$] = '{0, 5, 1, 5, 0, 5, 1, 5};
        apply_reset();
        pulse_start();
        foreach (seq[i]) drop_move(seq[i], "vwin");
        checks++;
        if ({state, game_status} !== 4'b1110) begin
            errors++;
            $display("FAIL vwin_final: state/status=%b expected 1110", {state, game_status});
        end
        pulse_start();
        checks++;
        if ({state, game_status} !== 4'b0100 || dut_board_vec() !== model_board_vec()) begin
            errors++;
            $display("FAIL restart: state/status=%b board=%h expected 0100 %h",
                     {state, game_status}, dut_board_vec(), model_board_vec());
        end
        drop_move(6, "restart_drop");
    endtask

    // Main sequence and report
    initial begin
        reset = 1'b1;
        start = 1'b0;
        drop  = 1'b0;
        col   = 3'd0;
        test_reset();
        test_first_move();
        test_horizontal_win();
        test_column_full();
        test_tie();
        test_busy_drop();
        test_vertical_p2();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
